// File: rtl/dac_output_stage.sv
// dac_output_stage: soft-start/soft-stop gain ramp followed by saturation to the DAC word width.
// Optional feature macro DAC_OUTPUT_CLIP_COUNT_EN adds a saturating clip_count output.
module dac_output_stage #(
   parameter int IN_WIDTH  = 19,
   parameter int OUT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        signal_valid,
   input  logic signed [IN_WIDTH-1:0]  signal_in,
   input  logic                        enable,
   input  logic        [15:0]          ramp_step,
   output logic                        dac_valid,
   output logic signed [OUT_WIDTH-1:0] dac_out,
   output logic        [1:0]           ramp_state,
`ifdef DAC_OUTPUT_CLIP_COUNT_EN
   output logic        [31:0]          clip_count,
`endif
   output logic                        clipped
);

   localparam int          PW      = IN_WIDTH + 18;
   localparam logic [16:0] G_UNITY = 17'h08000;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      ACTIVE    = 2'd2,
      RAMP_DOWN = 2'd3
   } state_t;

   state_t                      r_state;
   logic        [16:0]          r_gain;
   logic        [17:0]          w_gain_up_sum;
   logic        [16:0]          w_gain_up;
   logic        [16:0]          w_gain_dn;

   logic                        r_s1_valid;
   logic signed [IN_WIDTH-1:0]  r_s1_sample;
   logic        [16:0]          r_s1_gain;
   logic                        r_s2_valid;
   logic signed [PW-1:0]        r_s2_prod;
   logic signed [PW-1:0]        w_mul_a;
   logic signed [PW-1:0]        w_mul_b;

   logic signed [PW-1:0]        w_scaled;
   logic        [PW-OUT_WIDTH:0] w_scaled_hi;
   logic                        w_fits;
   logic signed [OUT_WIDTH-1:0] w_sat;
   logic                        w_unused;

   logic                        r_dac_valid;
   logic signed [OUT_WIDTH-1:0] r_dac_out;
   logic                        r_clipped;

   // Candidate gains for one ramp step; a zero step jumps straight to the end point.
   always_comb begin
      w_gain_up_sum = {1'b0, r_gain} + {2'b00, ramp_step};
      if ((ramp_step == 16'd0) || (w_gain_up_sum >= {1'b0, G_UNITY})) begin
         w_gain_up = G_UNITY;
      end else begin
         w_gain_up = w_gain_up_sum[16:0];
      end
      if ((ramp_step == 16'd0) || ({1'b0, ramp_step} >= r_gain)) begin
         w_gain_dn = 17'd0;
      end else begin
         w_gain_dn = r_gain - {1'b0, ramp_step};
      end
   end

   // Ramp FSM; an enable change wins over a gain update in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_gain  <= 17'd0;
      end else begin
         case (r_state)
            IDLE: begin
               r_gain <= 17'd0;
               if (enable) r_state <= RAMP_UP;
            end
            RAMP_UP: begin
               if (!enable) begin
                  r_state <= RAMP_DOWN;
               end else if (signal_valid) begin
                  r_gain <= w_gain_up;
                  if (w_gain_up == G_UNITY) r_state <= ACTIVE;
               end
            end
            ACTIVE: begin
               r_gain <= G_UNITY;
               if (!enable) r_state <= RAMP_DOWN;
            end
            RAMP_DOWN: begin
               if (enable) begin
                  r_state <= RAMP_UP;
               end else if (signal_valid) begin
                  r_gain <= w_gain_dn;
                  if (w_gain_dn == 17'd0) r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_gain  <= 17'd0;
            end
         endcase
      end
   end

   assign w_mul_a     = PW'(r_s1_sample);
   assign w_mul_b     = PW'($signed({1'b0, r_s1_gain}));
   assign w_scaled    = r_s2_prod >>> 15;
   assign w_scaled_hi = w_scaled[PW-1:OUT_WIDTH-1];
   assign w_fits      = (&w_scaled_hi) | ~(|w_scaled_hi);
   assign w_unused    = ^r_s2_prod[14:0];

   // Saturate toward the sign of the scaled value when it does not fit.
   always_comb begin
      if (w_fits) begin
         w_sat = w_scaled[OUT_WIDTH-1:0];
      end else if (w_scaled[PW-1]) begin
         w_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
         w_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
   end

   // Three-stage pipeline: capture, multiply, scale/saturate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_sample <= '0;
         r_s1_gain   <= 17'd0;
         r_s2_valid  <= 1'b0;
         r_s2_prod   <= '0;
         r_dac_valid <= 1'b0;
         r_dac_out   <= '0;
         r_clipped   <= 1'b0;
      end else begin
         r_s1_valid  <= signal_valid;
         r_s1_sample <= signal_in;
         r_s1_gain   <= r_gain;
         r_s2_valid  <= r_s1_valid;
         r_s2_prod   <= w_mul_a * w_mul_b;
         r_dac_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_dac_out <= w_sat;
            r_clipped <= ~w_fits;
         end else begin
            r_clipped <= 1'b0;
         end
      end
   end

`ifdef DAC_OUTPUT_CLIP_COUNT_EN
   logic        r_enable_d;
   logic [31:0] r_clip_count;

   // Saturating clip counter, restarted whenever the channel is switched on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_enable_d   <= 1'b0;
         r_clip_count <= 32'd0;
      end else begin
         r_enable_d <= enable;
         if (enable && !r_enable_d) begin
            r_clip_count <= 32'd0;
         end else if (r_dac_valid && r_clipped && (r_clip_count != 32'hFFFF_FFFF)) begin
            r_clip_count <= r_clip_count + 32'd1;
         end
      end
   end

   assign clip_count = r_clip_count;
`endif

   assign dac_valid  = r_dac_valid;
   assign dac_out    = r_dac_out;
   assign clipped    = r_clipped;
   assign ramp_state = r_state;

endmodule

// File: tb/tb_dac_output_stage.sv
// Scoreboard bench for dac_output_stage: a gain-ramp reference model feeds an expected queue
// that an independent output monitor drains.
module tb_dac_output_stage;

   localparam int IN_W  = 19;
   localparam int OUT_W = 16;

   logic                    clk          = 1'b0;
   logic                    rst          = 1'b0;
   logic                    signal_valid = 1'b0;
   logic signed [IN_W-1:0]  signal_in    = '0;
   logic                    enable       = 1'b0;
   logic        [15:0]      ramp_step    = 16'd0;
   logic                    dac_valid;
   logic signed [OUT_W-1:0] dac_out;
   logic        [1:0]       ramp_state;
   logic                    clipped;
`ifdef DAC_OUTPUT_CLIP_COUNT_EN
   logic        [31:0]      clip_count;
`endif

   dac_output_stage #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .signal_valid (signal_valid),
      .signal_in    (signal_in),
      .enable       (enable),
      .ramp_step    (ramp_step),
      .dac_valid    (dac_valid),
      .dac_out      (dac_out),
      .ramp_state   (ramp_state),
`ifdef DAC_OUTPUT_CLIP_COUNT_EN
      .clip_count   (clip_count),
`endif
      .clipped      (clipped)
   );

   always #5 clk = ~clk;

   typedef struct {
      int value;
      bit clip;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec    = 0;
   int   n_err    = 0;
   int   m_state  = 0;
   int   m_gain   = 0;
   int   last_out = 0;

   task automatic check(input string name, input longint act, input longint req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: floor(s*g/32768) clamped to the output range.
   function automatic exp_t model_sample(input int s, input int g);
      longint p;
      longint q;
      exp_t   e;
      p = longint'(s) * longint'(g);
      q = p / 32768;
      if ((p < 0) && ((p % 32768) != 0)) q = q - 1;
      if (q > 32767) begin
         e.value = 32767;
         e.clip  = 1'b1;
      end else if (q < -32768) begin
         e.value = -32768;
         e.clip  = 1'b1;
      end else begin
         e.value = int'(q);
         e.clip  = 1'b0;
      end
      return e;
   endfunction

   task automatic model_step(input bit en, input bit v, input int step);
      case (m_state)
         0: begin
            m_gain = 0;
            if (en) m_state = 1;
         end
         1: begin
            if (!en) m_state = 3;
            else if (v) begin
               if (step == 0 || m_gain + step > 32768) m_gain = 32768;
               else m_gain = m_gain + step;
               if (m_gain == 32768) m_state = 2;
            end
         end
         2: if (!en) m_state = 3;
         3: begin
            if (en) m_state = 1;
            else if (v) begin
               if (step == 0 || m_gain - step < 0) m_gain = 0;
               else m_gain = m_gain - step;
               if (m_gain == 0) m_state = 0;
            end
         end
         default: m_state = 0;
      endcase
   endtask

   function automatic int rand_sig();
      int r;
      r = int'($urandom_range(0, 524287));
      return (r >= 262144) ? (r - 524288) : r;
   endfunction

   function automatic int rand_step();
      case ($urandom_range(0, 3))
         0:       return 0;
         1:       return int'($urandom_range(1, 255));
         2:       return int'($urandom_range(256, 8192));
         default: return int'($urandom_range(0, 65535));
      endcase
   endfunction

   task automatic apply(input bit v, input int s, input bit en, input int step);
      signal_valid = v;
      signal_in    = s[IN_W-1:0];
      enable       = en;
      ramp_step    = step[15:0];
      if (v) exp_q.push_back(model_sample(s, m_gain));
      model_step(en, v, step);
      @(posedge clk);
      #1;
      check("ramp_state", ramp_state, m_state);
   endtask

   task automatic do_reset(input bit en);
      rst          = 1'b1;
      signal_valid = 1'b0;
      enable       = en;
      #1;
      check("rst_dac_valid", dac_valid, 0);
      check("rst_dac_out", dac_out, 0);
      check("rst_clipped", clipped, 0);
      check("rst_ramp_state", ramp_state, 0);
`ifdef DAC_OUTPUT_CLIP_COUNT_EN
      check("rst_clip_count", clip_count, 0);
`endif
      exp_q.delete();
      m_state = 0;
      m_gain  = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            last_out = 0;
         end else if (dac_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", dac_valid, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("dac_out", dac_out, e.value);
               check("clipped", clipped, e.clip);
               last_out = e.value;
            end
         end else begin
            check("hold_dac_out", dac_out, last_out);
            check("invalid_clipped", clipped, 0);
         end
      end
   end

   initial begin
      bit en;
      @(posedge clk);
      #1;
      do_reset(1'b1);

      repeat (20) apply(1'b1, 1000, 1'b1, 2048);
      repeat (3)  apply(1'b1, 200000, 1'b1, 2048);
      repeat (3)  apply(1'b1, -200000, 1'b1, 2048);
      repeat (20) apply(1'b1, rand_sig(), 1'b0, 2048);

      repeat (9)  apply(1'b1, 1000, 1'b1, 2048);
      repeat (10) apply(1'b1, 1000, 1'b0, 2048);

      repeat (3)  apply(1'b1, 5000, 1'b0, 0);
      repeat (4)  apply(1'b1, -7777, 1'b1, 0);
      repeat (3)  apply(1'b1, 1234, 1'b0, 0);

      for (int i = 0; i < 40; i++) apply(i % 2 == 0, rand_sig(), 1'b1, 16'h0300);
      for (int i = 0; i < 40; i++) apply(i % 3 != 0, rand_sig(), 1'b0, 16'h0500);

      en = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) en = ~en;
         apply($urandom_range(0, 3) != 0, rand_sig(), en, rand_step());
      end

      repeat (30) apply(1'b1, 1000, 1'b1, 16'h0100);
      repeat (5)  apply(1'b1, 1000, 1'b0, 16'h0100);
      do_reset(1'b1);

      repeat (20) apply(1'b1, rand_sig(), 1'b1, 16'h1000);
      repeat (6)  apply(1'b0, 0, 1'b1, 16'h1000);
      check("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dac_output_stage.md
# dac_output_stage

Final stage of the DAC path, downstream of the signal composer. It takes the composed 19-bit signal and its valid strobe, applies a soft-start/soft-stop gain ramp controlled by a per-channel enable, then saturates the result to the DAC word width. It stops the analog output from stepping abruptly when a channel is switched on or off.

## Interface
Parameters:
- IN_WIDTH, 19, width of the composed input sample (signed)
- OUT_WIDTH, 16, width of the saturated output sample (signed); must be ≤ IN_WIDTH

Ports:
- clk  input  1  sample clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- signal_valid  input  1  input sample strobe from the composer
- signal_in  input  IN_WIDTH  composed sample, signed two's complement
- enable  input  1  channel enable; level-sensitive
- ramp_step  input  16  unsigned gain increment per valid sample
- dac_valid  output  1  output sample strobe
- dac_out  output  OUT_WIDTH  gained, saturated sample, signed
- ramp_state  output  2  0=IDLE, 1=RAMP_UP, 2=ACTIVE, 3=RAMP_DOWN
- clipped  output  1  high for one cycle with a dac_valid sample that was saturated

## Operation
- Gain register g: 17-bit unsigned, range 0..32768 (0x8000 = unity).
- State machine, evaluated every cycle:
  - IDLE: g=0. If enable=1, go to RAMP_UP.
  - RAMP_UP: on each signal_valid=1 cycle, g ← min(g+ramp_step, 32768). When g reaches 32768, go to ACTIVE. If enable=0, go to RAMP_DOWN with g unchanged.
  - ACTIVE: g=32768. If enable=0, go to RAMP_DOWN.
  - RAMP_DOWN: on each signal_valid=1 cycle, g ← max(g−ramp_step, 0). When g reaches 0, go to IDLE. If enable=1, go to RAMP_UP with g unchanged.
- ramp_step=0: no ramp. In RAMP_UP, g is set to 32768; in RAMP_DOWN, g is set to 0. Either happens on the next valid cycle.
- g does not move on cycles where signal_valid=0.
- Arithmetic:
  - product p = signal_in × g, signed, IN_WIDTH+18 bits.
  - scaled = p >>> 15, arithmetic shift, truncating toward −∞.
  - Saturate scaled to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
  - clipped=1 when scaled lies outside that range.
- Each sample uses the g value in effect at the cycle it is captured, before the update caused by that sample.
- When a valid sample arrives in IDLE, dac_out=0 and dac_valid still follows signal_valid.
- When signal_valid=0, dac_out holds its previous value and clipped=0.

## Timing
- Pipeline has 3 stages:
  - S1: capture signal_in and g.
  - S2: multiply.
  - S3: shift, saturate, register outputs.
- dac_valid is signal_valid delayed by 3 cycles.
- dac_out and clipped are aligned with dac_valid.
- Full throughput: one sample per clock; no backpressure.
- enable is sampled every cycle. A state change takes effect on the next edge. The first gain change applies to the first valid sample captured after that edge.
- If enable toggles and signal_valid=1 in the same cycle, the transition is taken first; no g update occurs in that cycle.
- ramp_state is registered and reflects the state of the current cycle.
- Reset values: dac_valid=0, dac_out=0, clipped=0, ramp_state=IDLE, g=0, all pipeline registers 0.
- Asserting rst mid-ramp clears everything immediately. On release, the block restarts from IDLE; if enable=1, it enters RAMP_UP on the first edge after release.

## Configuration
- DAC_OUTPUT_CLIP_COUNT_EN:
  - Defined: adds output port clip_count (32-bit). It increments on every cycle with dac_valid=1 and clipped=1, saturates at 0xFFFFFFFF, and is cleared by rst and by a rising edge of enable.
  - Undefined: the port and counter are absent; the clipped flag is still present.

## Test plan
- Reset release with enable=1, ramp_step=0x0800, continuous valid, signal_in=+1000 → 16 valid samples to ACTIVE. dac_out steps 0, 62, 125, …, ending at 1000 in steady state, with 3-cycle latency.
- ACTIVE, signal_in=+200000 (OUT_WIDTH=16) → dac_out=32767, clipped=1. signal_in=−200000 → dac_out=−32768, clipped=1.
- Mid RAMP_UP at g=0x4000, drop enable → RAMP_DOWN from 0x4000, reaching IDLE after 8 valid samples with step 0x0800; dac_out ends at 0.
- ramp_step=0, enable 0→1 → g=32768 on the first valid sample; ACTIVE on the next cycle; dac_out=signal_in after 3 cycles.
- signal_valid toggling 1/0 during a ramp → g advances only on valid cycles; dac_out holds and clipped=0 on invalid cycles.
- Assert rst during RAMP_DOWN → all outputs 0 and ramp_state=IDLE in the same cycle. With DAC_OUTPUT_CLIP_COUNT_EN defined, clip_count=0.
